// File: rtl/pong_pkg.sv
// Shared encodings and limits for the match controller and its helpers.
// Combinational constants only; no timing or flow control.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_SERVE  = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam int MODE_TIMED    = 0;
  localparam int MODE_FIRST_TO = 1;
  localparam int MODE_EITHER   = 2;

  localparam int MAX_PLAYERS = 4;
  localparam int WINNER_W    = $clog2(MAX_PLAYERS);

endpackage

// File: rtl/edge_detect.sv
// Single-edge detector: pulse is high for the cycle in which d differs from its registered copy.
// Combinational pulse from one register stage; no backpressure.
module edge_detect #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign pulse = RISING ? (d & ~d_q) : (~d & d_q);

endmodule

// File: rtl/match_controller.sv
// Match sequencing for a pong game: serve delay, miss scoring, pause, timeout and result.
// All outputs registered (one cycle from input); inputs are never stalled.
module match_controller
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 200,
  parameter int MODE        = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           time_up,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic [2:0]                     state,
  output logic                           stop,
  output logic                           serve_req,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [WINNER_W-1:0]            winner,
  output logic                           result_valid,
  output logic                           tie
);

  localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);
  localparam int IDX_W = $clog2(NUM_PLAYERS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam bit TIMEOUT_EN = (MODE != MODE_FIRST_TO);
  localparam bit WIN_EN     = (MODE != MODE_TIMED);

  state_t               state_q, state_nx;
  logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]   score_nx[NUM_PLAYERS];
  logic [CNT_W-1:0]     cnt_q, cnt_nx;
  logic                 serve_req_nx;
  logic                 start_ev, pause_fall, timeout;
  logic [IDX_W-1:0]     miss_idx, credit_idx;
  logic [SCORE_W-1:0]   credited, best;
  logic [WINNER_W-1:0]  win_nx;
  logic                 tie_nx;

  edge_detect #(.RISING(1'b1)) u_start_ed (.clk(clk), .rst(rst), .d(start), .pulse(start_ev));
  edge_detect #(.RISING(1'b0)) u_pause_ed (.clk(clk), .rst(rst), .d(pause), .pulse(pause_fall));

  assign timeout = time_up && TIMEOUT_EN;

  always_comb begin
    state_nx     = state_q;
    score_nx     = score_q;
    cnt_nx       = cnt_q;
    serve_req_nx = 1'b0;
    // Lowest set miss bit wins; the next player round the table scores.
    miss_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (miss[i]) miss_idx = IDX_W'(i);
    end
    credit_idx = (miss_idx == IDX_W'(NUM_PLAYERS - 1)) ? '0 : miss_idx + IDX_W'(1);
    credited   = (score_q[credit_idx] == SCORE_MAX) ? SCORE_MAX
                                                    : score_q[credit_idx] + SCORE_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          for (int i = 0; i < NUM_PLAYERS; i++) score_nx[i] = '0;
          cnt_nx       = CNT_W'(SERVE_TICKS);
          serve_req_nx = 1'b1;
          state_nx     = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (timeout) begin
          state_nx = ST_OVER;
        end else if (|miss) begin
          score_nx[credit_idx] = credited;
          if (WIN_EN && (32'(credited) == WIN_SCORE)) begin
            state_nx = ST_OVER;
          end else begin
            cnt_nx       = CNT_W'(SERVE_TICKS);
            serve_req_nx = 1'b1;
            state_nx     = ST_SERVE;
          end
        end else if (pause) begin
          state_nx = ST_PAUSED;
        end
      end
      ST_SERVE: begin
        if (timeout) begin
          state_nx = ST_OVER;
        end else if (cnt_q == '0) begin
          state_nx = ST_PLAY;
        end else if (tick && !pause) begin
          cnt_nx = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_nx = ST_PLAY;
        end
      end
      ST_PAUSED: begin
        if (timeout)                     state_nx = ST_OVER;
        else if (pause_fall || start_ev) state_nx = ST_PLAY;
      end
      ST_OVER: begin
        if (start_ev) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Result is taken from the scores being registered, so it lines up with OVER.
  always_comb begin
    best   = score_nx[0];
    win_nx = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (score_nx[i] > best) begin
        best   = score_nx[i];
        win_nx = WINNER_W'(i);
      end
    end
    tie_nx = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if ((score_nx[i] == best) && (WINNER_W'(i) != win_nx)) tie_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      cnt_q        <= '0;
      serve_req    <= 1'b0;
      stop         <= 1'b1;
      result_valid <= 1'b0;
      tie          <= 1'b0;
      winner       <= '0;
    end else begin
      state_q      <= state_nx;
      score_q      <= score_nx;
      cnt_q        <= cnt_nx;
      serve_req    <= serve_req_nx;
      stop         <= (state_nx != ST_PLAY);
      result_valid <= (state_nx == ST_OVER);
      tie          <= (state_nx == ST_OVER) && tie_nx;
      if (state_nx == ST_OVER) winner <= win_nx;
    end
  end

  assign state = state_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

endmodule

// File: tb/tb_match_controller.sv
// Three differently parameterised controllers share one stimulus stream; each is
// compared every cycle against a rule-level model, plus literal scenario expectations.
module tb_match_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, pause = 1'b0, time_up = 1'b0;
  logic [2:0] miss = '0;

  logic [2:0]  st_a, st_b, st_c;
  logic        stop_a, stop_b, stop_c, sreq_a, sreq_b, sreq_c;
  logic        rv_a, rv_b, rv_c, tie_a, tie_b, tie_c;
  logic [1:0]  win_a, win_b, win_c;
  logic [7:0]  sc_a;
  logic [3:0]  sc_b;
  logic [11:0] sc_c;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;

  localparam int P_N   [3] = '{2, 2, 3};
  localparam int P_SW  [3] = '{4, 2, 4};
  localparam int P_WS  [3] = '{3, 7, 7};
  localparam int P_MODE[3] = '{2, 1, 0};
  localparam int P_T       = 5;
  string tag[3] = '{"A", "B", "C"};

  match_controller #(.NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(3), .SERVE_TICKS(5), .MODE(2)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .time_up(time_up),
    .miss(miss[1:0]), .state(st_a), .stop(stop_a), .serve_req(sreq_a), .scores(sc_a),
    .winner(win_a), .result_valid(rv_a), .tie(tie_a));

  match_controller #(.NUM_PLAYERS(2), .SCORE_W(2), .WIN_SCORE(7), .SERVE_TICKS(5), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .time_up(time_up),
    .miss(miss[1:0]), .state(st_b), .stop(stop_b), .serve_req(sreq_b), .scores(sc_b),
    .winner(win_b), .result_valid(rv_b), .tie(tie_b));

  match_controller #(.NUM_PLAYERS(3), .SCORE_W(4), .WIN_SCORE(7), .SERVE_TICKS(5), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .time_up(time_up),
    .miss(miss), .state(st_c), .stop(stop_c), .serve_req(sreq_c), .scores(sc_c),
    .winner(win_c), .result_valid(rv_c), .tie(tie_c));

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 play, 2 serve, 3 paused, 4 over
  int m_st[3], m_cnt[3], m_win[3];
  int m_sc[3][4];
  bit m_sreq[3], m_tie[3], m_sp[3], m_pp[3];

  task automatic mdl_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_win[k] = 0;
      m_sreq[k] = 0; m_tie[k] = 0; m_sp[k] = 0; m_pp[k] = 0;
      for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
    end
  endtask

  task automatic mdl_step(input int k);
    int n, smax, lo, p, best, nbest;
    bit sev, pfall, to;
    n     = P_N[k];
    smax  = (1 << P_SW[k]) - 1;
    sev   = start && !m_sp[k];
    pfall = !pause && m_pp[k];
    m_sp[k] = start;
    m_pp[k] = pause;
    to = time_up && (P_MODE[k] != 1);
    m_sreq[k] = 0;
    lo = -1;
    for (int i = n - 1; i >= 0; i--) if (miss[i]) lo = i;
    case (m_st[k])
      0: if (sev) begin
           for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
           m_sreq[k] = 1; m_st[k] = 2; m_cnt[k] = P_T;
         end
      1: if (to) m_st[k] = 4;
         else if (lo >= 0) begin
           p = (lo + 1) % n;
           if (m_sc[k][p] < smax) m_sc[k][p]++;
           if (m_sc[k][p] == P_WS[k] && P_MODE[k] != 0) m_st[k] = 4;
           else begin m_sreq[k] = 1; m_st[k] = 2; m_cnt[k] = P_T; end
         end else if (pause) m_st[k] = 3;
      2: if (to) m_st[k] = 4;
         else if (m_cnt[k] == 0) m_st[k] = 1;
         else if (tick && !pause) begin
           m_cnt[k]--;
           if (m_cnt[k] == 0) m_st[k] = 1;
         end
      3: if (to) m_st[k] = 4;
         else if (pfall || sev) m_st[k] = 1;
      4: if (sev) m_st[k] = 0;
      default: m_st[k] = 0;
    endcase
    m_tie[k] = 0;
    if (m_st[k] == 4) begin
      best = -1; nbest = 0;
      for (int i = 0; i < n; i++) if (m_sc[k][i] > best) begin best = m_sc[k][i]; m_win[k] = i; end
      for (int i = 0; i < n; i++) if (m_sc[k][i] == best) nbest++;
      m_tie[k] = (nbest > 1);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) mdl_reset();
    else for (int k = 0; k < 3; k++) mdl_step(k);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int score_of(input int k, input int i);
    case (k)
      0:       return int'(sc_a[i*4 +: 4]);
      1:       return int'(sc_b[i*2 +: 2]);
      default: return int'(sc_c[i*4 +: 4]);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int a_st, a_stop, a_sreq, a_win, a_rv, a_tie;
        case (k)
          0:       begin a_st = int'(st_a); a_stop = int'(stop_a); a_sreq = int'(sreq_a);
                         a_win = int'(win_a); a_rv = int'(rv_a); a_tie = int'(tie_a); end
          1:       begin a_st = int'(st_b); a_stop = int'(stop_b); a_sreq = int'(sreq_b);
                         a_win = int'(win_b); a_rv = int'(rv_b); a_tie = int'(tie_b); end
          default: begin a_st = int'(st_c); a_stop = int'(stop_c); a_sreq = int'(sreq_c);
                         a_win = int'(win_c); a_rv = int'(rv_c); a_tie = int'(tie_c); end
        endcase
        chk({tag[k], ".state"},        a_st,   m_st[k]);
        chk({tag[k], ".stop"},         a_stop, (m_st[k] != 1) ? 1 : 0);
        chk({tag[k], ".serve_req"},    a_sreq, int'(m_sreq[k]));
        chk({tag[k], ".result_valid"}, a_rv,   (m_st[k] == 4) ? 1 : 0);
        chk({tag[k], ".tie"},          a_tie,  int'(m_tie[k]));
        chk({tag[k], ".winner"},       a_win,  m_win[k]);
        for (int i = 0; i < P_N[k]; i++) chk({tag[k], ".score"}, score_of(k, i), m_sc[k][i]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic serve5();
    for (int i = 0; i < 5; i++) begin tick = 1'b1; cyc(); tick = 1'b0; end
  endtask

  initial begin
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) cyc();
    chk("rst.A.state", int'(st_a), 0);
    chk("rst.A.stop", int'(stop_a), 1);
    chk("rst.A.serve_req", int'(sreq_a), 0);
    chk("rst.A.result_valid", int'(rv_a), 0);
    chk("rst.A.scores", int'(sc_a), 0);
    chk("rst.A.winner", int'(win_a), 0);
    chk("rst.A.tie", int'(tie_a), 0);
    rst = 1'b1;
    cyc();

    // Start edge, then serve delay of five ticks
    start = 1'b1; cyc();
    chk("S045.A.serve_req", int'(sreq_a), 1);
    chk("S045.A.state", int'(st_a), 2);
    start = 1'b0; cyc();
    chk("S045.A.serve_req_drop", int'(sreq_a), 0);
    for (int i = 1; i <= 5; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      if (i < 5) chk("S045.A.wait", int'(st_a), 2);
    end
    chk("S045.A.play", int'(st_a), 1);
    chk("S045.A.stop", int'(stop_a), 0);

    // Simultaneous misses: only the lowest index counts
    miss = 3'b011; cyc(); miss = '0;
    chk("S046.A.scores", int'(sc_a), 'h10);
    chk("S046.C.scores", int'(sc_c), 'h010);
    chk("S046.A.serve_req", int'(sreq_a), 1);
    serve5();
    chk("S046.A.play", int'(st_a), 1);

    // Pause while ticks run, then release
    pause = 1'b1; cyc();
    chk("S047.A.paused", int'(st_a), 3);
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("S047.A.stop", int'(stop_a), 1);
    end
    pause = 1'b0; cyc();
    chk("S047.A.resume", int'(st_a), 1);
    chk("S047.A.scores", int'(sc_a), 'h10);

    // Fresh match: player 0 reaches WIN_SCORE on dut A
    rst = 1'b0; cyc(); rst = 1'b1;
    start = 1'b1; cyc(); start = 1'b0; serve5();
    for (int r = 0; r < 3; r++) begin
      miss = 3'b010; cyc(); miss = '0;
      if (r < 2) serve5();
    end
    chk("S044.A.state", int'(st_a), 4);
    chk("S044.A.scores", int'(sc_a), 'h03);
    chk("S044.A.winner", int'(win_a), 0);
    chk("S044.A.tie", int'(tie_a), 0);
    chk("S044.A.result_valid", int'(rv_a), 1);
    chk("S044.A.stop", int'(stop_a), 1);
    serve5();

    // Saturation on the 2-bit counters of dut B, then reset mid-play
    for (int r = 0; r < 2; r++) begin
      miss = 3'b010; cyc(); miss = '0; serve5();
    end
    chk("S049.B.scores", int'(sc_b), 'h3);
    chk("S049.B.state", int'(st_b), 1);
    chk("S049.A.held", int'(sc_a), 'h03);
    rst = 1'b0; #1;
    chk("S049.B.rst_state", int'(st_b), 0);
    chk("S049.B.rst_stop", int'(stop_b), 1);
    chk("S049.B.rst_scores", int'(sc_b), 0);
    chk("S049.A.rst_result_valid", int'(rv_a), 0);
    chk("S049.A.rst_scores", int'(sc_a), 0);
    cyc(); rst = 1'b1;

    // 2-2 then time_up: timed modes end, first-to mode keeps playing
    start = 1'b1; cyc(); start = 1'b0; serve5();
    for (int r = 0; r < 2; r++) begin miss = 3'b100; cyc(); miss = '0; serve5(); end
    for (int r = 0; r < 2; r++) begin miss = 3'b001; cyc(); miss = '0; serve5(); end
    time_up = 1'b1; cyc(); time_up = 1'b0;
    chk("S048.C.state", int'(st_c), 4);
    chk("S048.C.tie", int'(tie_c), 1);
    chk("S048.C.winner", int'(win_c), 0);
    chk("S048.C.scores", int'(sc_c), 'h022);
    chk("S048.B.state", int'(st_b), 1);
    chk("S048.A.state", int'(st_a), 4);
    chk("S048.A.winner", int'(win_a), 1);
    chk("S048.A.tie", int'(tie_a), 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("S048.C.idle", int'(st_c), 0);
    chk("S048.C.retained", int'(sc_c), 'h022);
    chk("S048.C.tie_clear", int'(tie_c), 0);
    cyc();

    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) start = ~start;
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if (!time_up) time_up = ($urandom_range(0, 299) == 0);
      else          time_up = ($urandom_range(0, 3) != 0);
      miss = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rst  = ($urandom_range(0, 699) != 0);
      cyc();
    end
    rst = 1'b1; tick = 1'b0; miss = '0;
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
